mac_dot_ctrl: RTL

//  Sequencer that computes one signed dot product on a single external 8-bit MAC.
//  On start it clears the MAC and streams LEN operand pairs from an operand

---
 rtl/mac_dot_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mac_dot_ctrl.sv
// Dot-product sequencer: streams operand pairs from a 1-cycle-latency buffer into an external MAC.
// Optional build macro MAC_DOT_RELU_EN: clamps negative results to zero on capture.
module mac_dot_ctrl #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_a,
  input  logic [7:0]        rd_b,
  output logic              mac_clear,
  output logic              mac_en,
  output logic [7:0]        mac_a,
  output logic [7:0]        mac_b,
  input  logic [31:0]       mac_acc
);

  localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CntOne = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StDrain,
    StFin
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
  logic [31:0]       result_q, result_d;
  logic [ADDR_W:0]   len_clamped;
  logic [31:0]       fin_value;

  assign len_clamped = (len > MaxLen) ? MaxLen : len;

`ifdef MAC_DOT_RELU_EN
  assign fin_value = mac_acc[31] ? 32'd0 : mac_acc;
`else
  assign fin_value = mac_acc;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StClear;
          len_d   = len_clamped;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d = CntOne;
        if (len_q == '0) begin
          state_d = StFin;
        end else if (len_q == CntOne) begin
          state_d = StDrain;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_q + CntOne;
        // Address cnt_q is the last one when cnt_q == L-1
        if ((cnt_q + CntOne) == len_q) begin
          state_d = StDrain;
        end
      end
      StDrain: state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy       = 1'b0;
    mac_clear  = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    done_d     = 1'b0;
    result_d   = result_q;
    unique case (state_q)
      StIdle: ;
      StClear: begin
        busy      = 1'b1;
        mac_clear = 1'b1;
        rd_en     = (len_q != '0);
      end
      StRun: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = cnt_q[ADDR_W-1:0];
      end
      StDrain: busy = 1'b1;
      StFin: begin
        busy     = 1'b1;
        done_d   = 1'b1;
        result_d = fin_value;
      end
      default: ;
    endcase
    rd_valid_d = rd_en;
  end

  assign done   = done_q;
  assign result = result_q;
  assign mac_en = rd_valid_q;
  assign mac_a  = rd_a;
  assign mac_b  = rd_b;

`ifndef SYNTHESIS
  // The MAC must never see clear and enable together
  assert property (@(posedge clk) disable iff (rst) !(mac_en && mac_clear));
  assert property (@(posedge clk) disable iff (rst) !(done && busy));
`endif

endmodule
